// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, blank digit and one-hot test for the keypad capture block
package keypad_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;
  localparam logic [9:0] BLANK = 10'b0;
  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != BLANK) && ((v & (v - 10'd1)) == BLANK);
  endfunction
endpackage

// File: rtl/keypad_digit_capture_sync2_bus.sv
// sync2_bus: two-flop synchroniser for a bus of independent asynchronous lines
module sync2_bus #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  // shift each raw line through two flops before anything downstream looks at it
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2_q, s1_q} <= '0;
    else {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture: debounces ten key lines into a held one-hot digit with valid/err strobes
module keypad_digit_capture
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys,
  input  logic       clr,
  output logic [9:0] bcd,
  output logic       valid,
  output logic       err,
  output logic       busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       cand_q, cand_d, bcd_q, bcd_d, keys_s;
  logic             valid_q, valid_d, err_q, err_d;
  sync2_bus #(.W(10)) u_sync (.clk(clk), .rst(rst), .d_i(keys), .q_o(keys_s));
  // state, counter, candidate and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= BLANK;
      bcd_q   <= BLANK;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  // next state: clr overrides everything; HOLD and RELEASE share the release-wait rule
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      bcd_d   = BLANK;
    end else begin
      case (state_q)
        IDLE:
          if (is_onehot10(keys_s)) begin
            cand_d  = keys_s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else if (keys_s != BLANK) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RELEASE;
          end
        DEBOUNCE:
          if (keys_s != cand_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == LAST) begin
            bcd_d   = cand_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end else cnt_d = cnt_q + CNT_W'(1);
        default:
          if (keys_s != BLANK) cnt_d = '0;
          else if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + CNT_W'(1);
      endcase
    end
  end
  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_keypad_digit_capture.sv
// tb_keypad_digit_capture: directed stimulus with a strobe scoreboard checked by a separate monitor
module tb_keypad_digit_capture;
  logic       clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [9:0] keys = 10'b0;
  logic [9:0] bcd;
  logic       valid, err, busy;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {
    bit         is_err;
    logic [9:0] bcd;
    int         edge_no;
  } ev_t;
  ev_t sb[$];
  ev_t ev;
  localparam logic [9:0] K2 = 10'b0010000000, K3 = 10'b0001000000, K4 = 10'b0000100000;
  localparam logic [9:0] K5 = 10'b0000010000, K6 = 10'b0000001000, K8 = 10'b0000000010;
  localparam logic [9:0] K9 = 10'b0000000001;

  keypad_digit_capture dut (
    .clk(clk), .rst(rst), .keys(keys), .clr(clr),
    .bcd(bcd), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit is_err, input logic [9:0] b, input int edge_no);
    sb.push_back('{is_err, b, edge_no});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // key driven at negedge of edge c is first sampled at c+1; accept lands on c+7
  task automatic press(input logic [9:0] k, input int hold);
    keys = k;
    expect_ev(1'b0, k, cyc + 7);
    tick(hold);
    keys = 10'b0;
    tick(8);
  endtask

  always @(negedge clk)
    if (!rst && (valid || err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_strobe: got valid=%0b err=%0b bcd=%b at edge %0d want no strobe",
                 valid, err, bcd, cyc);
      end else begin
        ev = sb.pop_front();
        chk("strobe_err", err, ev.is_err);
        chk("strobe_valid", valid, !ev.is_err);
        chk("strobe_bcd", bcd, ev.bcd);
        chk("strobe_edge", cyc, ev.edge_no);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    tick(2);
    chk("rst_bcd", bcd, 10'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(2);
    keys = K4;
    tick(4);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd, 10'b0);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    keys = 10'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    press(K4, 10);
    chk("repress_bcd", bcd, K4);
    c = cyc;
    keys = K6;
    expect_ev(1'b0, K6, c + 7);
    tick(6);
    chk("clean_bcd_before", bcd, K4);
    tick(14);
    chk("clean_bcd", bcd, K6);
    keys = 10'b0;
    tick(5);
    chk("release_busy_hi", busy, 1'b1);
    tick(1);
    chk("release_busy_lo", busy, 1'b0);
    tick(4);
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      keys = K3;
      tick(2);
      keys = 10'b0;
      tick(2);
    end
    keys = K3;
    expect_ev(1'b0, K3, c + 16 + 7);
    tick(12);
    chk("bounce_bcd", bcd, K3);
    keys = 10'b0;
    tick(8);
    c = cyc;
    keys = 10'b1000000001;
    expect_ev(1'b1, K3, c + 3);
    tick(5);
    chk("multi_busy", busy, 1'b1);
    chk("multi_bcd", bcd, K3);
    keys = 10'b0;
    tick(5);
    chk("multi_rel_busy_hi", busy, 1'b1);
    tick(1);
    chk("multi_rel_busy_lo", busy, 1'b0);
    tick(2);
    press(K2, 10);
    chk("after_multi_bcd", bcd, K2);
    keys = K5;
    expect_ev(1'b0, K5, cyc + 7);
    tick(10);
    keys = K5 | K8;
    tick(10);
    chk("extra_bcd", bcd, K5);
    chk("extra_busy", busy, 1'b1);
    keys = 10'b0;
    tick(8);
    c = cyc;
    keys = K9;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_bcd", bcd, 10'b0);
    chk("clr_valid", valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    expect_ev(1'b0, K9, c + 12);
    tick(10);
    chk("reaccept_bcd", bcd, K9);
    keys = 10'b0;
    tick(10);
    chk("final_busy", busy, 1'b0);
    while (sb.size() > 0) begin
      ev = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_strobe: got none want err=%0b bcd=%b at edge %0d",
               ev.is_err, ev.bcd, ev.edge_no);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
